output_layer: RTL and testbench

- Final stage of the min-sum decoder. Sits directly downstream of the last interm_layer.
- Consumes that layer's edge messages and the channel LLRs, and forms one posterior LLR per variable node: channel LLR plus all incoming edge messages.
- Saturates each posterior and emits the posteriors plus hard-decision bits to the host/output interface.
- Accumulates serially, one edge per cycle, to bound adder count.

---
 rtl/output_layer_pkg.sv | 52 +++++
 rtl/output_layer_saturate.sv | 23 ++
 rtl/output_layer.sv | 178 +++++++++++++++++
 tb/tb_output_layer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/output_layer_pkg.sv
// Shared Tanner-graph constants and FSM encoding for the decoder output stage.
package output_layer_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned N_V_DEF   = 44;
  localparam int unsigned E_DEF     = 147;
  localparam int unsigned ACC_W_DEF = 12;
  localparam int unsigned VN_IDX_W  = $clog2(N_V_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_SAT   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Edge-to-VN map shared by variable_nodes, check_nodes and output_layer:
  // edges are laid out round-robin over the variable nodes.
  function automatic logic [E_DEF*VN_IDX_W-1:0] build_edge_vn();
    logic [E_DEF*VN_IDX_W-1:0] map;
    map = '0;
    for (int unsigned e = 0; e < E_DEF; e++) begin
      map[e*VN_IDX_W +: VN_IDX_W] = VN_IDX_W'(e % N_V_DEF);
    end
    return map;
  endfunction

  localparam logic [E_DEF*VN_IDX_W-1:0] EDGE_VN = build_edge_vn();

  // Number of edges landing on variable node v.
  function automatic int unsigned vn_degree(input int unsigned v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned e = 0; e < E_DEF; e++) begin
      if (EDGE_VN[e*VN_IDX_W +: VN_IDX_W] == VN_IDX_W'(v)) cnt++;
    end
    return cnt;
  endfunction

  // Largest VN degree; sizes the accumulator headroom.
  function automatic int unsigned max_vn_degree();
    int unsigned best;
    best = 0;
    for (int unsigned v = 0; v < N_V_DEF; v++) begin
      if (vn_degree(v) > best) best = vn_degree(v);
    end
    return best;
  endfunction

  localparam int unsigned MAX_VN_DEG = max_vn_degree();

endpackage

// File: rtl/output_layer_saturate.sv
// Symmetric clamp of a wide accumulator to a WIDTH-bit LLR; the most negative code is never produced.
module llr_saturate #(
  parameter int unsigned ACC_W = 12,
  parameter int unsigned WIDTH = 8
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [WIDTH-1:0] sat_c
);

  localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [ACC_W-1:0] NEG_LIM = -POS_LIM;

  // Clamp to +/-(2^(WIDTH-1)-1), otherwise pass the low bits through.
  always_comb begin
    sat_c = acc_i[WIDTH-1:0];
    if (acc_i > POS_LIM) begin
      sat_c = POS_LIM[WIDTH-1:0];
    end else if (acc_i < NEG_LIM) begin
      sat_c = NEG_LIM[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/output_layer.sv
// Decoder output stage: serial per-edge posterior accumulation, saturation and hard decisions.
module output_layer
  import output_layer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned N_V   = N_V_DEF,
  parameter int unsigned E     = E_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter logic [E*VN_IDX_W-1:0] EDGE_VN_MAP = EDGE_VN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prev_ready,
  input  logic [WIDTH*N_V-1:0] all_llrs,
  input  logic [WIDTH*E-1:0]   prev_proc_elem,
  input  logic                 out_ack,
  output logic [WIDTH*N_V-1:0] posterior_llrs,
  output logic [N_V-1:0]       decoded_bits,
  output logic                 out_valid,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned EC_W = (E > 1) ? $clog2(E) : 1;

  // Worst-case VN degree of the map actually in use.
  function automatic int unsigned map_max_deg();
    int unsigned best;
    int unsigned cnt;
    best = 0;
    for (int unsigned v = 0; v < N_V; v++) begin
      cnt = 0;
      for (int unsigned e = 0; e < E; e++) begin
        if (EDGE_VN_MAP[e*VN_IDX_W +: VN_IDX_W] == VN_IDX_W'(v)) cnt++;
      end
      if (cnt > best) best = cnt;
    end
    return best;
  endfunction

  localparam int unsigned MAX_DEG  = map_max_deg();
  localparam int unsigned NEED_ACC = WIDTH + $clog2(MAX_DEG + 1);

  if (ACC_W < NEED_ACC) begin : g_acc_w_check
    $error("output_layer: ACC_W too narrow for the graph degree");
  end

  state_e                  state_q, state_d;
  logic [EC_W-1:0]         edge_q, edge_d;
  logic [WIDTH-1:0]        msg_q [E];
  logic [WIDTH-1:0]        msg_d [E];
  logic signed [ACC_W-1:0] acc_q [N_V];
  logic signed [ACC_W-1:0] acc_d [N_V];
  logic [WIDTH*N_V-1:0]    post_q, post_d;
  logic [N_V-1:0]          bits_q, bits_d;
  logic                    out_valid_q, out_valid_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;

  logic signed [WIDTH-1:0] sat_c [N_V];
  logic                    accept_c;
  logic [VN_IDX_W-1:0]     edge_vn_c;
  logic [WIDTH-1:0]        msg_cur_c;
  logic signed [ACC_W-1:0] msg_ext_c;

  // A frame is taken in IDLE, or in DONE when the held result is being acknowledged.
  assign accept_c  = prev_ready &&
                     ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_valid_q && out_ack));
  assign edge_vn_c = EDGE_VN_MAP[edge_q*VN_IDX_W +: VN_IDX_W];
  assign msg_cur_c = msg_q[edge_q];
  assign msg_ext_c = {{(ACC_W-WIDTH){msg_cur_c[WIDTH-1]}}, msg_cur_c};

  // One clamp per variable node, sampled into the output register in SAT.
  for (genvar v = 0; v < N_V; v++) begin : g_sat
    llr_saturate #(
      .ACC_W(ACC_W),
      .WIDTH(WIDTH)
    ) u_sat (
      .acc_i(acc_q[v]),
      .sat_c(sat_c[v])
    );
  end

  // Next-state, accumulator update and output register logic.
  always_comb begin
    state_d     = state_q;
    edge_d      = edge_q;
    msg_d       = msg_q;
    acc_d       = acc_q;
    post_d      = post_q;
    bits_d      = bits_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    unique case (state_q)
      ST_IDLE: begin
      end
      ST_ACCUM: begin
        for (int unsigned v = 0; v < N_V; v++) begin
          if (edge_vn_c == VN_IDX_W'(v)) acc_d[v] = acc_q[v] + msg_ext_c;
        end
        if (edge_q == EC_W'(E - 1)) begin
          state_d = ST_SAT;
          edge_d  = '0;
        end else begin
          edge_d = edge_q + EC_W'(1);
        end
      end
      ST_SAT: begin
        for (int unsigned v = 0; v < N_V; v++) begin
          post_d[WIDTH*v +: WIDTH] = sat_c[v];
          bits_d[v]                = sat_c[v][WIDTH-1];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // Posteriors settle one cycle ahead of out_valid.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_ack) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept_c) begin
      for (int unsigned e = 0; e < E; e++) begin
        msg_d[e] = prev_proc_elem[WIDTH*e +: WIDTH];
      end
      for (int unsigned v = 0; v < N_V; v++) begin
        acc_d[v] = {{(ACC_W-WIDTH){all_llrs[WIDTH*v+WIDTH-1]}}, all_llrs[WIDTH*v +: WIDTH]};
      end
      edge_d  = '0;
      state_d = ST_ACCUM;
    end

    if (prev_ready && !accept_c) overrun_d = 1'b1;

    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      edge_q      <= '0;
      post_q      <= '0;
      bits_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int unsigned v = 0; v < N_V; v++) acc_q[v] <= '0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      post_q      <= post_d;
      bits_q      <= bits_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      acc_q       <= acc_d;
    end
  end

  // Message register; only meaningful after an accepted frame, so left unreset.
  always_ff @(posedge clk) begin
    msg_q <= msg_d;
  end

  assign posterior_llrs = post_q;
  assign decoded_bits   = bits_q;
  assign out_valid      = out_valid_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_output_layer.sv
// Self-checking bench for output_layer on a 4-VN / 6-edge test graph.
module tb_output_layer;
  import output_layer_pkg::*;

  localparam int unsigned W   = 8;
  localparam int unsigned NV  = 4;
  localparam int unsigned NE  = 6;
  localparam int unsigned AW  = 12;
  localparam int unsigned LAT = NE + 2;
  localparam int EVN [NE] = '{0, 0, 1, 2, 3, 3};

  function automatic logic [NE*VN_IDX_W-1:0] tb_map();
    logic [NE*VN_IDX_W-1:0] m;
    m = '0;
    for (int e = 0; e < NE; e++) m[e*VN_IDX_W +: VN_IDX_W] = VN_IDX_W'(EVN[e]);
    return m;
  endfunction

  localparam logic [NE*VN_IDX_W-1:0] MAP = tb_map();

  logic            clk = 1'b0;
  logic            rst;
  logic            prev_ready;
  logic [W*NV-1:0] all_llrs;
  logic [W*NE-1:0] prev_proc_elem;
  logic            out_ack;
  logic [W*NV-1:0] posterior_llrs;
  logic [NV-1:0]   decoded_bits;
  logic            out_valid;
  logic            busy;
  logic            overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  output_layer #(
    .WIDTH(W), .N_V(NV), .E(NE), .ACC_W(AW), .EDGE_VN_MAP(MAP)
  ) dut (
    .clk(clk), .rst(rst), .prev_ready(prev_ready), .all_llrs(all_llrs),
    .prev_proc_elem(prev_proc_elem), .out_ack(out_ack),
    .posterior_llrs(posterior_llrs), .decoded_bits(decoded_bits),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W*NV-1:0] llrs;
    logic [W*NE-1:0] msgs;
    logic [W*NV-1:0] exp_post;
    logic [NV-1:0]   exp_bits;
  } vec_t;

  function automatic logic [W*NV-1:0] pk4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  function automatic logic [W*NE-1:0] pk6(input int a, input int b, input int c,
                                          input int d, input int e, input int f);
    return {8'(f), 8'(e), 8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Reference: posterior = clamp(channel + sum of messages on that VN's edges).
  task automatic ref_model(input logic [W*NV-1:0] l, input logic [W*NE-1:0] m,
                           output logic [W*NV-1:0] post, output logic [NV-1:0] bits);
    int s;
    logic signed [W-1:0] x;
    post = '0;
    bits = '0;
    for (int v = 0; v < NV; v++) begin
      x = l[W*v +: W];
      s = int'(x);
      for (int e = 0; e < NE; e++) begin
        if (EVN[e] == v) begin
          x = m[W*e +: W];
          s += int'(x);
        end
      end
      if (s > 127) s = 127;
      if (s < -127) s = -127;
      post[W*v +: W] = 8'(s);
      bits[v] = (s < 0);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic start_frame(input logic [W*NV-1:0] l, input logic [W*NE-1:0] m);
    @(negedge clk);
    all_llrs       = l;
    prev_proc_elem = m;
    prev_ready     = 1'b1;
    @(negedge clk);
    prev_ready     = 1'b0;
    all_llrs       = $urandom;
    prev_proc_elem = {16'($urandom), $urandom};
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
  endtask

  task automatic check_result(input string name, input logic [W*NV-1:0] ep, input logic [NV-1:0] eb);
    chk({name, " post"}, 64'(posterior_llrs), 64'(ep));
    chk({name, " bits"}, 64'(decoded_bits), 64'(eb));
  endtask

  task automatic ack_frame(input string name);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    chk({name, " ack valid"}, 64'(out_valid), 64'(0));
    chk({name, " ack busy"}, 64'(busy), 64'(0));
  endtask

  vec_t            tbl [4];
  logic [W*NV-1:0] l, l2, ep, ep2;
  logic [W*NE-1:0] m, m2;
  logic [NV-1:0]   eb, eb2;

  initial begin
    tbl[0] = '{pk4(5, -3, 0, 1), pk6(2, 2, -4, 0, -1, -1), pk4(9, -7, 0, -1), 4'b1010};
    tbl[1] = '{pk4(100, -128, 0, 0), pk6(100, 100, -128, 0, 0, 0), pk4(127, -127, 0, 0), 4'b0010};
    tbl[2] = '{pk4(-1, 2, -50, 60), pk6(-3, 3, 10, -70, -60, -1), pk4(-1, 12, -120, -1), 4'b1101};
    tbl[3] = '{pk4(127, -127, 127, -128), pk6(127, 127, 127, -128, -128, -128),
               pk4(127, 0, -1, -127), 4'b1100};

    rst = 1'b1; prev_ready = 1'b0; out_ack = 1'b0;
    all_llrs = '0; prev_proc_elem = '0;
    repeat (3) @(negedge clk);
    chk("reset valid", 64'(out_valid), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset overrun", 64'(overrun), 64'(0));
    chk("reset post", 64'(posterior_llrs), 64'(0));
    chk("reset bits", 64'(decoded_bits), 64'(0));
    rst = 1'b0;

    // Directed vectors
    for (int i = 0; i < 4; i++) begin
      start_frame(tbl[i].llrs, tbl[i].msgs);
      chk("vec busy", 64'(busy), 64'(1));
      wait_valid("vec", LAT);
      check_result("vec", tbl[i].exp_post, tbl[i].exp_bits);
      ack_frame("vec");
    end

    // Random frames against the reference model
    for (int i = 0; i < 30; i++) begin
      l = $urandom;
      m = {16'($urandom), $urandom};
      ref_model(l, m, ep, eb);
      start_frame(l, m);
      wait_valid("rnd", LAT);
      check_result("rnd", ep, eb);
      chk("rnd overrun", 64'(overrun), 64'(0));
      ack_frame("rnd");
    end

    // Hold without acknowledge for 20 cycles
    l = pk4(5, -3, 0, 1);
    m = pk6(2, 2, -4, 0, -1, -1);
    ref_model(l, m, ep, eb);
    start_frame(l, m);
    wait_valid("hold", LAT);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold post", 64'(posterior_llrs), 64'(ep));
      chk("hold valid", 64'(out_valid), 64'(1));
      chk("hold busy", 64'(busy), 64'(1));
    end
    ack_frame("hold");

    // Back-to-back: ack and new frame in the same DONE cycle
    l = $urandom; m = {16'($urandom), $urandom};
    l2 = $urandom; m2 = {16'($urandom), $urandom};
    ref_model(l, m, ep, eb);
    ref_model(l2, m2, ep2, eb2);
    start_frame(l, m);
    wait_valid("b2b first", LAT);
    check_result("b2b first", ep, eb);
    out_ack = 1'b1; prev_ready = 1'b1; all_llrs = l2; prev_proc_elem = m2;
    @(negedge clk);
    out_ack = 1'b0; prev_ready = 1'b0; all_llrs = $urandom; prev_proc_elem = {16'($urandom), $urandom};
    chk("b2b valid drop", 64'(out_valid), 64'(0));
    chk("b2b busy", 64'(busy), 64'(1));
    wait_valid("b2b second", LAT);
    check_result("b2b second", ep2, eb2);
    chk("b2b overrun", 64'(overrun), 64'(0));
    ack_frame("b2b");

    // Overrun: pulse mid-ACCUM is dropped and flagged
    l = pk4(-10, 20, -30, 40); m = pk6(1, 2, 3, 4, 5, 6);
    ref_model(l, m, ep, eb);
    start_frame(l, m);
    repeat (3) @(negedge clk);
    prev_ready = 1'b1; all_llrs = '1; prev_proc_elem = '1;
    @(negedge clk);
    prev_ready = 1'b0;
    chk("ovr flag", 64'(overrun), 64'(1));
    wait_valid("ovr", LAT - 4);
    check_result("ovr", ep, eb);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("ovr no 2nd frame", 64'(out_valid), 64'(0));
    end
    chk("ovr sticky", 64'(overrun), 64'(1));

    // Reset mid-ACCUM then fresh frame
    start_frame(pk4(50, 50, 50, 50), pk6(10, 10, 10, 10, 10, 10));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst valid", 64'(out_valid), 64'(0));
    chk("mid rst busy", 64'(busy), 64'(0));
    chk("mid rst overrun", 64'(overrun), 64'(0));
    chk("mid rst post", 64'(posterior_llrs), 64'(0));
    chk("mid rst bits", 64'(decoded_bits), 64'(0));
    l = pk4(-7, 3, 9, -2); m = pk6(-1, -1, 4, -20, 1, 0);
    ref_model(l, m, ep, eb);
    start_frame(l, m);
    wait_valid("post rst", LAT);
    check_result("post rst", ep, eb);
    ack_frame("post rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
